// File: rtl/piso_shift_register.sv
// Free-running parallel-in / serial-out shift register. A word is captured at
// the start of every WIDTH-cycle frame and shifted out one bit per clock.
module piso_shift_register #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         parallel_in,
  output logic                     serial_out,
  output logic                     frame_start,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             serial_out_q, serial_out_d;
  logic             frame_start_q, frame_start_d;
  logic [CW-1:0]    bit_idx_q, bit_idx_d;
  logic             load_s;

  // cnt == 0 marks the first edge of a frame, where the new word is captured
  assign load_s = (cnt_q == {CW{1'b0}});

  // Next-state for the shift register, frame counter and output flops
  always_comb begin
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    serial_out_d  = serial_out_q;
    frame_start_d = frame_start_q;
    bit_idx_d     = bit_idx_q;

    if (load_s) begin
      if (MSB_FIRST) begin
        serial_out_d = parallel_in[WIDTH-1];
        shreg_d      = parallel_in << 1;
      end else begin
        serial_out_d = parallel_in[0];
        shreg_d      = parallel_in >> 1;
      end
      frame_start_d = 1'b1;
      bit_idx_d     = {CW{1'b0}};
    end else begin
      if (MSB_FIRST) begin
        serial_out_d = shreg_q[WIDTH-1];
        shreg_d      = shreg_q << 1;
      end else begin
        serial_out_d = shreg_q[0];
        shreg_d      = shreg_q >> 1;
      end
      frame_start_d = 1'b0;
      bit_idx_d     = cnt_q;
    end

    // Explicit wrap so non-power-of-two WIDTH still gives WIDTH-cycle frames
    if (cnt_q == CNT_LAST) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State and output registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q       <= {WIDTH{1'b0}};
      cnt_q         <= {CW{1'b0}};
      serial_out_q  <= 1'b0;
      frame_start_q <= 1'b0;
      bit_idx_q     <= {CW{1'b0}};
    end else begin
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      serial_out_q  <= serial_out_d;
      frame_start_q <= frame_start_d;
      bit_idx_q     <= bit_idx_d;
    end
  end

  assign serial_out  = serial_out_q;
  assign frame_start = frame_start_q;
  assign bit_idx     = bit_idx_q;

endmodule

// File: tb/tb_piso_shift_register.sv
// Bench for piso_shift_register: MSB-first and LSB-first instances share the
// stimulus; a word/position model checks every cycle, plus directed literals.
module tb_piso_shift_register;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pin;
  logic         ser_m, fs_m, ser_l, fs_l;
  logic [2:0]   idx_m, idx_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .parallel_in(pin),
    .serial_out(ser_m), .frame_start(fs_m), .bit_idx(idx_m)
  );

  piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .parallel_in(pin),
    .serial_out(ser_l), .frame_start(fs_l), .bit_idx(idx_l)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the word latched for the current frame and the position within it
  // (-1 = idle after reset, next edge loads).
  logic         valid_m = 1'b0;
  int           pos_m;
  logic [W-1:0] word_m;
  logic         frame_end_m;
  logic         exp_ser_m, exp_ser_l, exp_fs;
  int           exp_idx;

  assign frame_end_m = (pos_m < 0) || (pos_m == W - 1);

  always @(posedge clk) begin
    if (rst) begin
      valid_m <= 1'b1;
      pos_m   <= -1;
      word_m  <= '0;
    end else if (valid_m) begin
      pos_m  <= frame_end_m ? 0 : pos_m + 1;
      word_m <= frame_end_m ? pin : word_m;
    end
  end

  always_comb begin
    exp_ser_m = 1'b0;
    exp_ser_l = 1'b0;
    exp_fs    = 1'b0;
    exp_idx   = 0;
    if (pos_m >= 0) begin
      exp_ser_m = word_m[W-1-pos_m];
      exp_ser_l = word_m[pos_m];
      exp_fs    = (pos_m == 0);
      exp_idx   = pos_m;
    end
  end

  always @(negedge clk) begin
    if (valid_m) begin
      chk("sb_msb_serial", ser_m, exp_ser_m);
      chk("sb_msb_fstart", fs_m, exp_fs);
      chk("sb_msb_idx", idx_m, exp_idx);
      chk("sb_lsb_serial", ser_l, exp_ser_l);
      chk("sb_lsb_fstart", fs_l, exp_fs);
      chk("sb_lsb_idx", idx_l, exp_idx);
    end
  end

  logic [W-1:0] seq;

  initial begin
    rst = 1'b1;
    pin = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      chk("rst_serial", ser_m, 0);
      chk("rst_fstart", fs_m, 0);
      chk("rst_idx", idx_m, 0);
    end

    // First frame; parallel_in changes mid-frame must not disturb it
    rst = 1'b0;
    pin = 8'b1010_1010;
    seq = 8'b1010_1010;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("f1_serial", ser_m, seq[W-1-k]);
      chk("f1_fstart", fs_m, (k == 0) ? 1 : 0);
      chk("f1_idx", idx_m, k);
      if (k == 2) pin = 8'b1100_1100;
      if (k == 3) pin = 8'b1111_0000;
    end

    seq = 8'b1111_0000;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("f2_serial", ser_m, seq[W-1-k]);
      if (k == W - 1) pin = 8'b1100_1100;
    end

    // Three back-to-back frames of the same word
    seq = 8'b1100_1100;
    for (int k = 0; k < 3 * W; k++) begin
      @(negedge clk);
      chk("b2b_serial", ser_m, seq[W-1-(k%W)]);
      chk("b2b_fstart", fs_m, ((k % W) == 0) ? 1 : 0);
      if (k == 3 * W - 1) pin = 8'hF0;
    end

    // Reset lands while bit 4 of an F0 frame is on the line
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      chk("mid_idx", idx_m, k);
    end
    rst = 1'b1;
    pin = 8'h5A;
    @(negedge clk);
    chk("mid_rst_serial", ser_m, 0);
    chk("mid_rst_fstart", fs_m, 0);
    chk("mid_rst_idx", idx_m, 0);
    rst = 1'b0;
    seq = 8'h5A;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("restart_serial", ser_m, seq[W-1-k]);
      chk("restart_fstart", fs_m, (k == 0) ? 1 : 0);
      chk("restart_idx", idx_m, k);
    end

    // LSB-first order on the second instance
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pin = 8'b0000_0110;
    seq = 8'b0000_0110;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("lsb_serial", ser_l, seq[k]);
      chk("lsb_idx", idx_l, k);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_shift_register.md
Name: piso_shift_register

Overview:
- Parallel-in, serial-out shift register that runs free with no load strobe.
- Samples a WIDTH-bit parallel word at the start of each frame and shifts it out one bit per clock on serial_out.
- Each frame is exactly WIDTH cycles, and frames run back-to-back.
- Sits between a parallel data source and a single-wire serial sink. Frame-timing outputs let downstream logic align to word boundaries.

Parameters:
- WIDTH, 8, word length in bits and frame length in clock cycles (legal range >= 2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 is transmitted first; 0 = bit 0 is transmitted first.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset, synchronous and active-high; one clock.
- parallel_in  input  WIDTH  parallel word; sampled only on load edges.
- serial_out  output  1  registered serial data bit.
- frame_start  output  1  registered; high during the cycle in which serial_out carries the first bit of a frame.
- bit_idx  output  $clog2(WIDTH)  registered; position within the frame of the bit currently on serial_out (0 = first bit transmitted).

Behaviour:
- State: shift register shreg[WIDTH-1:0], counter cnt (0..WIDTH-1), output registers.
- Reset (rst=1 at a rising edge):
  - shreg=0, cnt=0.
  - serial_out=0, frame_start=0, bit_idx=0.
  - Reset has priority over every other action.
- Load edge: the rising edge with rst=0 and cnt==0.
  - MSB_FIRST=1: serial_out <= parallel_in[WIDTH-1]; shreg <= parallel_in << 1.
  - MSB_FIRST=0: serial_out <= parallel_in[0]; shreg <= parallel_in >> 1.
  - frame_start <= 1, bit_idx <= 0, cnt <= 1.
- Shift edge: rst=0 and cnt!=0.
  - MSB_FIRST=1: serial_out <= shreg[WIDTH-1]; shreg <= shreg << 1 (zero fill).
  - MSB_FIRST=0: serial_out <= shreg[0]; shreg <= shreg >> 1.
  - frame_start <= 0, bit_idx <= cnt.
  - cnt <= cnt+1, wrapping from WIDTH-1 to 0.
- Latency: the first bit of a word is on serial_out immediately after its load edge.
  - Bit k of the frame (transmission order) is valid for the cycle following edge (load+k), k = 0..WIDTH-1.
- Framing:
  - The first edge after rst deasserts is a load edge.
  - Load edges then occur every WIDTH clocks with no idle gap between frames.
- parallel_in changes between load edges are ignored and do not affect the frame in flight.
- Reset mid-frame:
  - Aborts the frame; the remaining bits are discarded.
  - Outputs return to reset values on that edge.
  - The next frame begins at the first edge with rst=0.
- Reset held for multiple cycles: outputs stay at reset values and no load occurs.
- All outputs come directly from flops, with no combinational path from inputs to outputs.

Test Plan:
- Reset: rst=1 for 1+ cycles, parallel_in=8'hFF -> serial_out=0, frame_start=0, bit_idx=0 throughout reset.
- Single frame, MSB_FIRST=1:
  - Stimulus: deassert rst with parallel_in=8'b10101010.
  - Required: serial_out sequence 1,0,1,0,1,0,1,0 over the 8 cycles after the load edge.
  - Required: frame_start high only on the first of those cycles; bit_idx 0..7.
- Input stability:
  - Stimulus: change parallel_in to 8'b11001100 then 8'b11110000 at mid-frame cycles 2 and 3.
  - Required: the current frame still outputs 10101010.
  - Required: the next frame outputs the value present at its load edge (11110000 -> 1,1,1,1,0,0,0,0).
- Back-to-back frames:
  - Stimulus: hold parallel_in=8'b11001100 for 24 cycles.
  - Required: pattern 11001100 repeats three times with no gap; frame_start pulses every 8 cycles.
- Reset mid-frame:
  - Stimulus: assert rst during bit_idx=4 of an 8'hF0 frame.
  - Required: serial_out=0 next cycle.
  - Required: after release, a fresh frame starts with bit_idx=0 from the new parallel_in.
- LSB-first:
  - Stimulus: MSB_FIRST=0, parallel_in=8'b00000110.
  - Required: serial_out sequence 0,1,1,0,0,0,0,0.
